// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  // True when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer plus history flop for one PS/2 pin.
// The output fall_o pulses when the synchronized level goes from 1 to 0.
module ps2_sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, hist_q;

  // The bus idles high, so all stages reset to 1 to avoid a false edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign fall_o  = hist_q & ~sync2_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 frame receiver with E0/F0 prefix absorption and an inactivity watchdog.
// Parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_ext,
  output logic       is_break,
  output logic       frame_err
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  logic clk_fall, clk_lvl_unused;
  logic data_lvl, data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .Clk     (Clk),
    .Reset   (Reset),
    .pin_i   (psClk),
    .level_o (clk_lvl_unused),
    .fall_o  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .Clk     (Clk),
    .Reset   (Reset),
    .pin_i   (psData),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           ext_pend_q, ext_pend_d;
  logic           brk_pend_q, brk_pend_d;
  logic [7:0]     code_q, code_d;
  logic           is_ext_q, is_ext_d;
  logic           is_break_q, is_break_d;
  logic           code_valid_q, code_valid_d;
  logic           frame_err_q, frame_err_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           parity_ok;
  logic           timeout;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = odd_parity_ok(shift_q, par_q);
`else
  // Bring-up build: the parity bit is still captured but never rejects a frame.
  logic parity_unused;
  assign parity_unused = odd_parity_ok(shift_q, par_q);
  assign parity_ok     = 1'b1;
`endif

  assign timeout = !clk_fall && (state_q != IDLE) && (wd_q == WDW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    code_d       = code_q;
    is_ext_d     = is_ext_q;
    is_break_d   = is_break_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    wd_d         = wd_q;

    if (clk_fall) begin
      wd_d = '0;
    end else if ((state_q != IDLE) && (wd_q != WDW'(TIMEOUT_CYC))) begin
      wd_d = wd_q + WDW'(1);
    end

    case (state_q)
      IDLE: begin
        if (clk_fall) begin
          if (!data_lvl) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (clk_fall) begin
          shift_d   = {data_lvl, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (clk_fall) begin
          par_d   = data_lvl;
          state_d = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          state_d = IDLE;
          if (data_lvl && parity_ok) begin
            if (shift_q == PS2_EXT_PREFIX) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BRK_PREFIX) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d       = shift_q;
              is_ext_d     = ext_pend_q;
              is_break_d   = brk_pend_q;
              code_valid_d = 1'b1;
              ext_pend_d   = 1'b0;
              brk_pend_d   = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall always clears the counter, so it can never coincide with a timeout.
    if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_q       <= 8'h00;
      is_ext_q     <= 1'b0;
      is_break_q   <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      code_q       <= code_d;
      is_ext_q     <= is_ext_d;
      is_break_q   <= is_break_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      wd_q         <= wd_d;
    end
  end

  assign code       = code_q;
  assign is_ext     = is_ext_q;
  assign is_break   = is_break_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed plus randomized bench for ps2_scancode_rx with a byte-level key-event model.
module tb_ps2_scancode_rx;

  localparam int H       = 8;
  localparam int TIMEOUT = 50000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       psClk;
  logic       psData;
  logic [7:0] code;
  logic       code_valid, is_ext, is_break, frame_err;

  ps2_scancode_rx #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .psClk      (psClk),
    .psData     (psData),
    .code       (code),
    .code_valid (code_valid),
    .is_ext     (is_ext),
    .is_break   (is_break),
    .frame_err  (frame_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cv = 0, n_fe = 0, n_both = 0, cv_cyc = 0, fe_cyc = 0;
  always @(negedge Clk) begin
    if (Reset !== 1'b1) begin
      if (code_valid === 1'b1) begin n_cv++; cv_cyc = cyc; end
      if (frame_err === 1'b1) begin n_fe++; fe_cyc = cyc; end
      if (code_valid === 1'b1 && frame_err === 1'b1) n_both++;
    end
  end

  int checks = 0, failures = 0;
  int last_fall_cyc = 0, stop_cyc = 0;

  // Model of the key-event stream: pending prefixes and the last reported event.
  bit       m_ext = 0, m_brk = 0;
  bit [7:0] m_code = 8'h00;
  bit       m_oext = 0, m_obrk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ps_bit(input logic b);
    psData = b;
    wait_cyc(H);
    psClk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(H);
    psClk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    logic [7:0] v;
    v = b;
    ps_bit(1'b0);
    for (int i = 0; i < 8; i++) ps_bit(v[i]);
    ps_bit((~^v) ^ flip_par);
    ps_bit(~bad_stop);
    stop_cyc = last_fall_cyc;
    psData = 1'b1;
    wait_cyc(H);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".code"}, {24'd0, code}, {24'd0, m_code});
    check({tag, ".is_ext"}, {31'd0, is_ext}, {31'd0, m_oext});
    check({tag, ".is_break"}, {31'd0, is_break}, {31'd0, m_obrk});
  endtask

  // Send one frame and check the resulting pulses and outputs against the model.
  task automatic run_frame(input string tag, input logic [7:0] b, input bit flip_par,
                           input bit bad_stop);
    int cv0, fe0, exp_cv, exp_fe;
    bit accepted;
    cv0 = n_cv; fe0 = n_fe; exp_cv = 0; exp_fe = 0;
    send_frame(b, flip_par, bad_stop);
    accepted = !bad_stop && (!flip_par || !PAR_EN);
    if (!accepted) begin
      exp_fe = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_cv = 1; m_code = b; m_oext = m_ext; m_obrk = m_brk; m_ext = 0; m_brk = 0;
    end
    check({tag, ".n_code_valid"}, n_cv - cv0, exp_cv);
    check({tag, ".n_frame_err"}, n_fe - fe0, exp_fe);
    // Edges counted from the stop-bit psClk fall to the edge where the consumer samples.
    if (exp_cv == 1) check({tag, ".latency"}, cv_cyc + 1 - stop_cyc, 4);
    if (exp_fe == 1) check({tag, ".err_latency"}, fe_cyc + 1 - stop_cyc, 4);
    check_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int cv0, fe0, sel;
    logic [7:0] rb;
    bit flip;

    Reset = 1'b1; psClk = 1'b1; psData = 1'b1;
    wait_cyc(4);
    check("reset.code_valid", {31'd0, code_valid}, 32'd0);
    check("reset.frame_err", {31'd0, frame_err}, 32'd0);
    check_outputs("reset");
    Reset = 1'b0;
    wait_cyc(4);

    run_frame("w_make", 8'h1D, 0, 0);

    run_frame("w_brk.f0", 8'hF0, 0, 0);
    run_frame("w_brk.1d", 8'h1D, 0, 0);

    run_frame("kp_up.e0", 8'hE0, 0, 0);
    run_frame("kp_up.f0", 8'hF0, 0, 0);
    run_frame("kp_up.75", 8'h75, 0, 0);
    run_frame("plain.1c", 8'h1C, 0, 0);

    run_frame("badpar.1d", 8'h1D, 1, 0);
    run_frame("badstop.2b", 8'h2B, 0, 1);

    cv0 = n_cv; fe0 = n_fe;
    ps_bit(1'b1);
    wait_cyc(H);
    check("badstart.n_frame_err", n_fe - fe0, 1);
    check("badstart.n_code_valid", n_cv - cv0, 0);
    run_frame("after_badstart.33", 8'h33, 0, 0);

    run_frame("tmo.e0", 8'hE0, 0, 0);
    cv0 = n_cv; fe0 = n_fe;
    ps_bit(1'b0);
    for (int i = 0; i < 5; i++) ps_bit(1'b1);
    psData = 1'b1;
    wait_cyc(TIMEOUT + 20);
    check("tmo.n_frame_err", n_fe - fe0, 1);
    check("tmo.n_code_valid", n_cv - cv0, 0);
    check("tmo.cycle", fe_cyc - last_fall_cyc, 3 + TIMEOUT);
    m_ext = 0; m_brk = 0;
    run_frame("tmo.23", 8'h23, 0, 0);

    run_frame("rst.e0", 8'hE0, 0, 0);
    cv0 = n_cv; fe0 = n_fe;
    ps_bit(1'b0);
    for (int i = 0; i < 3; i++) ps_bit(1'b1);
    Reset = 1'b1;
    psData = 1'b1;
    wait_cyc(2);
    m_ext = 0; m_brk = 0; m_code = 8'h00; m_oext = 0; m_obrk = 0;
    check("rst.code_valid", {31'd0, code_valid}, 32'd0);
    check("rst.frame_err", {31'd0, frame_err}, 32'd0);
    check_outputs("rst");
    Reset = 1'b0;
    wait_cyc(4);
    check("rst.no_pulse", (n_cv - cv0) + (n_fe - fe0), 0);
    run_frame("rst.1d", 8'h1D, 0, 0);

    for (int it = 0; it < 12; it++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        1: run_frame("rnd.pre", 8'hE0, 0, 0);
        2: run_frame("rnd.pre", 8'hF0, 0, 0);
        3: begin run_frame("rnd.pre", 8'hE0, 0, 0); run_frame("rnd.pre", 8'hF0, 0, 0); end
        4: begin run_frame("rnd.pre", 8'hF0, 0, 0); run_frame("rnd.pre", 8'hE0, 0, 0); end
        5: begin run_frame("rnd.pre", 8'hE0, 0, 0); run_frame("rnd.pre", 8'hE0, 0, 0); end
        default: ;
      endcase
      do rb = 8'($urandom); while (rb == 8'hE0 || rb == 8'hF0);
      flip = ($urandom_range(0, 5) == 0);
      run_frame("rnd.key", rb, flip, 0);
    end

    check("never_both", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
